// File: rtl/mux_arbiter_reg_mxn.sv
// Registered M-to-1 channel mux with a select port (MODE=0) or a round-robin arbiter (MODE=1).
// One cycle from accept to out_valid. A held word stalls all inputs until out_ready takes it.
module mux_arbiter_reg_mxn #(
  parameter int M = 4,
  parameter int N = 8,
  parameter int MODE = 0,
  localparam int SEL_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enabler,
  input  logic [SEL_W-1:0]      select,
  input  logic [M-1:0][N-1:0]   channels,
  input  logic [M-1:0]          in_valid,
  output logic [M-1:0]          in_ready,
  output logic [N-1:0]          channel_out,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] rr_q, rr_d;

  logic             load;
  logic             take;
  logic             cand_vld;
  logic [SEL_W-1:0] cand;

  assign load = !vld_q || out_ready;
  assign take = load && enabler && cand_vld;

  // Only indices below M can match, so an out-of-range select never yields a candidate.
  always_comb begin
    int idx;
    cand_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    if (MODE == 0) begin
      for (int i = 0; i < M; i++) begin
        if (!cand_vld && select == SEL_W'(i) && in_valid[i]) begin
          cand_vld = 1'b1;
          cand     = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= M; k++) begin
        idx = (int'(rr_q) + k) % M;
        if (!cand_vld && in_valid[idx]) begin
          cand_vld = 1'b1;
          cand     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < M; i++) begin
      in_ready[i] = rst_n && take && (cand == SEL_W'(i));
    end
  end

  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    rr_d   = rr_q;
    if (take) begin
      data_d = channels[cand];
      sel_d  = cand;
      vld_d  = 1'b1;
      if (MODE == 1) begin
        rr_d = cand;
      end
    end else if (load) begin
      // Idle output reads as zero; out_sel keeps the last granted index.
      vld_d  = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
      rr_q   <= SEL_W'(M - 1);
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
      rr_q   <= rr_d;
    end
  end

  assign channel_out = data_q;
  assign out_sel     = sel_q;
  assign out_valid   = vld_q;

endmodule

// File: tb/tb_mux_arbiter_reg_mxn.sv
// Bench for mux_arbiter_reg_mxn: select-mode M=4, round-robin M=4 and select-mode M=5 instances.
module tb_mux_arbiter_reg_mxn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MODE=0, M=4
  logic            en0, ordy0, ov0;
  logic [1:0]      sel0, os0;
  logic [3:0][7:0] ch0;
  logic [3:0]      iv0, ir0;
  logic [7:0]      co0;

  // MODE=1, M=4
  logic            en1, ordy1, ov1;
  logic [1:0]      sel1, os1;
  logic [3:0][7:0] ch1;
  logic [3:0]      iv1, ir1;
  logic [7:0]      co1;

  // MODE=0, M=5
  logic            en5, ordy5, ov5;
  logic [2:0]      sel5, os5;
  logic [4:0][7:0] ch5;
  logic [4:0]      iv5, ir5;
  logic [7:0]      co5;

  mux_arbiter_reg_mxn #(.M(4), .N(8), .MODE(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .enabler(en0), .select(sel0), .channels(ch0),
    .in_valid(iv0), .in_ready(ir0), .channel_out(co0), .out_sel(os0),
    .out_valid(ov0), .out_ready(ordy0)
  );

  mux_arbiter_reg_mxn #(.M(4), .N(8), .MODE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .enabler(en1), .select(sel1), .channels(ch1),
    .in_valid(iv1), .in_ready(ir1), .channel_out(co1), .out_sel(os1),
    .out_valid(ov1), .out_ready(ordy1)
  );

  mux_arbiter_reg_mxn #(.M(5), .N(8), .MODE(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .enabler(en5), .select(sel5), .channels(ch5),
    .in_valid(iv5), .in_ready(ir5), .channel_out(co5), .out_sel(os5),
    .out_valid(ov5), .out_ready(ordy5)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] iv;
    logic       en;
    logic       ordy;
    logic [3:0] exp_ir;
    logic       exp_vld;
    logic [7:0] exp_out;
    logic [1:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [3:0] iv;
    logic [1:0] exp_sel;
  } rr_t;

  vec_t vt[7];
  rr_t  rt[16];
  logic [7:0] rr_dat[4];

  initial begin
    // Select-mode vectors, applied in order; state carries between rows.
    vt[0] = '{2'd2, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    vt[1] = '{2'd1, 4'b1101, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2};
    vt[2] = '{2'd0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vt[3] = '{2'd1, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vt[4] = '{2'd3, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
    vt[5] = '{2'd0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vt[6] = '{2'd0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

    rt[0]  = '{4'b1111, 2'd0}; rt[1]  = '{4'b1111, 2'd1};
    rt[2]  = '{4'b1111, 2'd2}; rt[3]  = '{4'b1111, 2'd3};
    rt[4]  = '{4'b1111, 2'd0}; rt[5]  = '{4'b1111, 2'd1};
    rt[6]  = '{4'b1101, 2'd2}; rt[7]  = '{4'b1101, 2'd3};
    rt[8]  = '{4'b1101, 2'd0}; rt[9]  = '{4'b1101, 2'd2};
    rt[10] = '{4'b1000, 2'd3}; rt[11] = '{4'b1000, 2'd3};
    rt[12] = '{4'b1000, 2'd3}; rt[13] = '{4'b1001, 2'd0};
    rt[14] = '{4'b1001, 2'd3}; rt[15] = '{4'b1001, 2'd0};
    rr_dat = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    rst_n = 1'b0;
    ch0 = {8'h44, 8'h33, 8'h22, 8'h11};
    ch1 = {rr_dat[3], rr_dat[2], rr_dat[1], rr_dat[0]};
    ch5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    en0 = 1'b1; ordy0 = 1'b1; sel0 = 2'd0; iv0 = 4'b1111;
    en1 = 1'b1; ordy1 = 1'b1; sel1 = 2'd0; iv1 = 4'b1111;
    en5 = 1'b1; ordy5 = 1'b1; sel5 = 3'd0; iv5 = 5'b11111;

    // Reset state, with requests pending to show in_ready is held low.
    #2;
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_co0", 32'(co0), 32'd0);
    chk("rst_os0", 32'(os0), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd0);
    chk("rst_ir1", 32'(ir1), 32'd0);
    chk("rst_ov5", 32'(ov5), 32'd0);
    @(negedge clk);
    iv0 = 4'b0000; iv1 = 4'b0000; iv5 = 5'b00000;
    rst_n = 1'b1;

    // Select-mode table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sel0 = vt[i].sel; iv0 = vt[i].iv; en0 = vt[i].en; ordy0 = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(ir0), 32'(vt[i].exp_ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(ov0), 32'(vt[i].exp_vld));
      chk($sformatf("v%0d_channel_out", i), 32'(co0), 32'(vt[i].exp_out));
      chk($sformatf("v%0d_out_sel", i), 32'(os0), 32'(vt[i].exp_sel));
    end

    // Stall: hold 0x22 from channel 1 while inputs churn.
    @(negedge clk);
    sel0 = 2'd1; iv0 = 4'b0010; en0 = 1'b1; ordy0 = 1'b1;
    @(posedge clk); #1;
    chk("stall_cap_out", 32'(co0), 32'h22);
    chk("stall_cap_sel", 32'(os0), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ordy0 = 1'b0; sel0 = 2'(c); ch0[c % 4] = 8'hE0 + 8'(c); iv0 = 4'b1111;
      #1;
      chk($sformatf("stall%0d_in_ready", c), 32'(ir0), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_out", c), 32'(co0), 32'h22);
      chk($sformatf("stall%0d_sel", c), 32'(os0), 32'd1);
      chk($sformatf("stall%0d_vld", c), 32'(ov0), 32'd1);
    end
    @(negedge clk);
    ordy0 = 1'b1; sel0 = 2'd3; iv0 = 4'b1000; ch0[3] = 8'h5A;
    #1;
    chk("unstall_in_ready", 32'(ir0), 32'b1000);
    @(posedge clk); #1;
    chk("unstall_out", 32'(co0), 32'h5A);
    chk("unstall_sel", 32'(os0), 32'd3);
    @(negedge clk);
    iv0 = 4'b0000;

    // M=5: out-of-range selects never capture; index 4 does.
    @(negedge clk);
    sel5 = 3'd6; iv5 = 5'b11111;
    #1;
    chk("m5_sel6_in_ready", 32'(ir5), 32'd0);
    @(posedge clk); #1;
    chk("m5_sel6_vld", 32'(ov5), 32'd0);
    @(negedge clk);
    sel5 = 3'd4;
    #1;
    chk("m5_sel4_in_ready", 32'(ir5), 32'b10000);
    @(posedge clk); #1;
    chk("m5_sel4_out", 32'(co5), 32'h55);
    chk("m5_sel4_sel", 32'(os5), 32'd4);
    @(negedge clk);
    sel5 = 3'd7;
    #1;
    chk("m5_sel7_in_ready", 32'(ir5), 32'd0);
    @(posedge clk); #1;
    chk("m5_sel7_vld", 32'(ov5), 32'd0);
    chk("m5_sel7_out", 32'(co5), 32'd0);

    // Round-robin sequence, back-to-back with out_ready high.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      iv1 = rt[i].iv;
      #1;
      chk($sformatf("rr%0d_in_ready", i), 32'(ir1), 32'(4'b0001 << rt[i].exp_sel));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_out_sel", i), 32'(os1), 32'(rt[i].exp_sel));
      chk($sformatf("rr%0d_out_valid", i), 32'(ov1), 32'd1);
      chk($sformatf("rr%0d_out", i), 32'(co1), 32'(rr_dat[rt[i].exp_sel]));
    end

    // Asynchronous reset mid-cycle while holding a word.
    @(negedge clk);
    iv1 = 4'b0000; ordy1 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ov1", 32'(ov1), 32'd0);
    chk("arst_co1", 32'(co1), 32'd0);
    chk("arst_os1", 32'(os1), 32'd0);
    chk("arst_ov5", 32'(ov5), 32'd0);
    @(negedge clk);
    iv1 = 4'b1111; ordy1 = 1'b1;
    #1;
    chk("arst_hold_ir1", 32'(ir1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(ir1), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_sel", 32'(os1), 32'd0);
    chk("post_rst_vld", 32'(ov1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
